fir_stream_driver: RTL
======================

# fir_stream_driver

Host-side stream driver for the 15-tap wordlength-configurable FIR. It holds the per-tap fractional wordlength register file (`frac_wl`) and feeds host samples into the FIR's `data_in`/`in_valid` port. It appends the zero-flush beats the FIR needs, and returns every FIR result to the host over a valid/ready stream with a 4-entry buffer. One run is delimited by `s_last`; each run yields the full convolution.

## Interface
- `N_TAPS`, 15, FIR tap count; one flush run is `N_TAPS-1` beats.
- `IN_WL`, 12, sample width (4.8 signed).
- `OUT_WL`, 12, result width (4.8 signed).
- `FWL_W`, 8, width of each `frac_wl` entry.
- `FWL_RST`, 16, reset value of every `frac_wl` entry (full product precision).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  wordlength write strobe.
- `cfg_addr`  in  4  tap index.
- `cfg_data`  in  FWL_W  new fractional wordlength.
- `frac_wl`  out  FWL_W x N_TAPS  registered wordlength array, wired to the FIR `frac_wl`.
- `s_data`  in  IN_WL  host sample.
- `s_valid`  in  1  host sample valid.
- `s_last`  in  1  last sample of run.
- `s_ready`  out  1  sample accepted when `s_valid & s_ready`.
- `fir_data_in`  out  IN_WL  registered, to FIR `data_in`.
- `fir_in_valid`  out  1  registered, to FIR `in_valid`.
- `fir_data_out`  in  OUT_WL  from FIR `data_out`.
- `m_data`  out  OUT_WL  result.
- `m_valid`  out  1  result valid.
- `m_last`  out  1  last result of run.
- `m_ready`  in  1  host accepts result.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- **FSM states:** IDLE, RUN, FLUSH, DRAIN.
- **IDLE:**
  - Config writes are accepted here.
  - An accepted sample goes to RUN, or to FLUSH if `s_last` is set.
- **RUN:**
  - `s_ready` is high when buffer credit is available.
  - An accepted sample with `s_last` goes to FLUSH.
- **FLUSH:**
  - `s_ready` is 0.
  - The block issues `N_TAPS-1` beats with data 0, one per cycle, whenever credit is available.
  - After the final flush beat issues, the state goes to DRAIN.
- **DRAIN:**
  - The state returns to IDLE on the cycle the `m_last` result is popped (`m_valid & m_ready & m_last`).
- **Beat:** an accepted sample or a flush beat.
  - A beat registers `fir_data_in` and sets `fir_in_valid=1` for exactly one cycle.
  - Otherwise `fir_in_valid=0` and `fir_data_in` holds its value.
- **Capture:**
  - Two cycles after a beat is issued, `fir_data_out` is pushed into the 4-entry FIFO.
  - The FIR sum register updates at the end of the `fir_in_valid` cycle, and `data_out` is visible the next cycle.
  - A 2-stage in-flight shift register tracks issued beats and the last-beat flag.
  - The FIR `out_valid` is a warm-up flag only and is not used; every beat produces exactly one result.
- **Credit:** a beat may issue only when `fifo_count + inflight < 4`. Pop in the same cycle is ignored, so this is conservative.
- **Run output:** a run of N samples yields exactly N+14 results. `m_last` is set on the result of the final flush beat.
- **History:** the flush clears FIR history, so consecutive runs are independent.
- **Config writes:**
  - `cfg_we` in IDLE with `cfg_addr < N_TAPS` sets `frac_wl[cfg_addr]` at the clock edge.
  - Writes outside IDLE, or with `cfg_addr >= N_TAPS`, are dropped silently.
  - `frac_wl` is therefore constant for a whole run.
- **Simultaneous write and sample in IDLE:** the new wordlength applies to that sample's products, since the FIR uses `frac_wl` in the `fir_in_valid` cycle.
- **Reset values:**
  - `frac_wl` = `FWL_RST` for all taps.
  - `fir_in_valid`, `m_valid`, `m_last`, `busy` = 0; `fir_data_in` and `m_data` = 0.
  - FIFO empty, in-flight cleared, state IDLE.
  - `s_ready` = 1 in the first cycle after reset.
- **Reset mid-run:** any state aborts immediately and discards buffered results. The FIR shares `rst`, so its history is also cleared.

## Timing
- **Latency:** sample accepted in cycle t → `fir_in_valid` in t+1 → FIFO push at the end of t+2 → `m_valid` in t+3 with an empty FIFO.
- **Throughput:** with `m_ready` held at 1, one beat per cycle sustained. A run of N samples completes in N+14+3 cycles after the first accept.
- **Backpressure:**
  - With `m_ready=0`, at most 4 results are outstanding; `s_ready` and flush issue stall.
  - No result is lost or duplicated.
- **Output stability:** `m_data`/`m_last` stay stable while `m_valid & !m_ready`.
- **`busy` timing:** `busy` rises the cycle after the first accept and falls the cycle after the `m_last` pop.

## Test plan
- **Reset defaults:** assert `rst` for 2 cycles → all `frac_wl`=16, `m_valid`=0, `busy`=0, `s_ready`=1.
- **Impulse:** single sample 0x100 with `s_last` → exactly 15 results, `m_last` on the 15th.
  - Result 0 = 0x001, result 1 = 0xFFE, result 7 = 0x054, result 14 = 0x001.
  - First `m_valid` 3 cycles after accept.
- **Backpressure:** 20-sample ramp, `m_ready` low for 10 cycles mid-run.
  - `s_ready` low while `fifo_count+inflight`=4.
  - 34 results match the golden convolution, in order, none lost.
- **Config:**
  - In IDLE, write addr 7 = 0 → `frac_wl[7]`=0.
  - Write addr 15 → no change.
  - Write during RUN → no change.
  - Write plus sample in the same IDLE cycle → that sample uses the new value.
- **Back-to-back runs:** run of 3 samples, then run of 2 → 17 and 16 results; the second run equals the same run done after reset.
- **Reset mid-FLUSH:** `rst` at flush beat 5 → all outputs return to reset values; the following impulse run reproduces the impulse results exactly.

Source files
------------

// File: rtl/fir_stream_driver.sv
// fir_stream_driver
//   Host-side stream driver for the 15-tap wordlength-configurable FIR.
//   Holds the per-tap fractional wordlength register file, issues host
//   samples plus N_TAPS-1 zero flush beats per run into the FIR, captures
//   one FIR result per beat two cycles later and returns results to the
//   host through a 4-entry valid/ready buffer.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_data wordlength write (honoured only in IDLE)
//   frac_wl                  registered wordlength array to the FIR
//   s_data/s_valid/s_last    host sample stream, s_ready back-pressure
//   fir_data_in/fir_in_valid registered beat towards the FIR
//   fir_data_out             FIR result (sum register)
//   m_data/m_valid/m_last    result stream, m_ready from host
//   busy                     state is not IDLE
module fir_stream_driver #(
  parameter int N_TAPS  = 15,
  parameter int IN_WL   = 12,
  parameter int OUT_WL  = 12,
  parameter int FWL_W   = 8,
  parameter int FWL_RST = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [3:0]                    cfg_addr,
  input  logic [FWL_W-1:0]              cfg_data,
  output logic [N_TAPS-1:0][FWL_W-1:0]  frac_wl,
  input  logic [IN_WL-1:0]              s_data,
  input  logic                          s_valid,
  input  logic                          s_last,
  output logic                          s_ready,
  output logic [IN_WL-1:0]              fir_data_in,
  output logic                          fir_in_valid,
  input  logic [OUT_WL-1:0]             fir_data_out,
  output logic [OUT_WL-1:0]             m_data,
  output logic                          m_valid,
  output logic                          m_last,
  input  logic                          m_ready,
  output logic                          busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam int FC_W = $clog2(N_TAPS);

  logic [1:0]        state;
  logic [FC_W-1:0]   flush_cnt;
  // vld_pipe[0] mirrors fir_in_valid, vld_pipe[1] is the capture cycle
  logic [1:0]        vld_pipe;
  logic [1:0]        last_pipe;
  logic [2:0]        fifo_count;
  logic [1:0]        wr_ptr, rd_ptr;
  logic [OUT_WL-1:0] fifo_data [4];
  logic              fifo_last [4];

  logic [2:0] occ;
  logic       credit, s_fire, flush_fire, flush_final, beat, push, pop, cfg_ok;

  // Outstanding results = buffered + in flight. A same-cycle pop is not
  // credited, which keeps the limit safe at the cost of nothing in
  // steady state (occupancy sits at 3 with m_ready held high).
  assign occ         = fifo_count + {2'b0, vld_pipe[0]} + {2'b0, vld_pipe[1]};
  assign credit      = occ < 3'd4;
  assign s_ready     = ((state == S_IDLE) || (state == S_RUN)) && credit;
  assign s_fire      = s_valid && s_ready;
  assign flush_fire  = (state == S_FLUSH) && credit;
  assign flush_final = flush_fire && (flush_cnt == FC_W'(N_TAPS-2));
  assign beat        = s_fire || flush_fire;
  assign push        = vld_pipe[1];
  assign pop         = m_valid && m_ready;
  assign cfg_ok      = cfg_we && (state == S_IDLE) && (int'(cfg_addr) < N_TAPS);

  assign m_valid = (fifo_count != 3'd0);
  assign m_data  = fifo_data[rd_ptr];
  assign m_last  = m_valid && fifo_last[rd_ptr];
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) frac_wl[i] <= FWL_W'(FWL_RST);
    end else if (cfg_ok) begin
      for (int i = 0; i < N_TAPS; i++)
        if (cfg_addr == 4'(i)) frac_wl[i] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      flush_cnt    <= '0;
      fir_in_valid <= 1'b0;
      fir_data_in  <= '0;
      vld_pipe     <= '0;
      last_pipe    <= '0;
      fifo_count   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      for (int i = 0; i < 4; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      fir_in_valid <= beat;
      if (beat) fir_data_in <= s_fire ? s_data : '0;
      vld_pipe  <= {vld_pipe[0], beat};
      last_pipe <= {last_pipe[0], flush_final};

      // FIR sum register was loaded at the end of the fir_in_valid cycle
      if (push) begin
        fifo_data[wr_ptr] <= fir_data_out;
        fifo_last[wr_ptr] <= last_pipe[1];
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_count <= fifo_count + {2'b0, push} - {2'b0, pop};

      if (s_fire && s_last)  flush_cnt <= '0;
      else if (flush_fire)   flush_cnt <= flush_cnt + 1'b1;

      case (state)
        S_IDLE:  if (s_fire) state <= s_last ? S_FLUSH : S_RUN;
        S_RUN:   if (s_fire && s_last) state <= S_FLUSH;
        S_FLUSH: if (flush_final) state <= S_DRAIN;
        S_DRAIN: if (pop && m_last) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
